// File: rtl/mont_exp_ctrl.sv
// mont_exp_ctrl
//   Sequencer for result = x^e mod n using one shared Montgomery multiplier.
//   The exponent is scanned left to right (square-and-multiply) in the
//   Montgomery domain. The block owns the operand registers (X_tilde and the
//   accumulator A) and the operand muxing, and it issues one multiplication
//   at a time.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   start             level command; a job is accepted on its rising edge in IDLE
//   x, e, e_len, n    base, exponent, significant exponent bits, odd modulus
//   r2n               R^2 mod n with R = 2^W
//   busy, done        job in flight / result valid (held while in DONE)
//   result            registered x^e mod n
//   mm_start          one-cycle start pulse to the multiplier
//   mm_a, mm_b, mm_m  multiplier operands and modulus
//   mm_result         multiplier output; only [W-1:0] is used
//   mm_done           multiplier completion pulse
module mont_exp_ctrl #(
    parameter int W  = 1024,
    parameter int EW = 1024,
    parameter int LW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [EW-1:0] e,
    input  logic [LW-1:0] e_len,
    input  logic [W-1:0]  n,
    input  logic [W-1:0]  r2n,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          mm_start,
    output logic [W-1:0]  mm_a,
    output logic [W-1:0]  mm_b,
    output logic [W-1:0]  mm_m,
    input  logic [W:0]    mm_result,
    input  logic          mm_done
);

    typedef enum logic [2:0] {
        IDLE, INIT_X, INIT_A, SQUARE, MULT, POST, DONE
    } state_t;

    localparam logic [LW-1:0] EW_L = LW'(EW);

    state_t        state, state_d;
    logic          start_q;
    logic          issued;      // start pulse of the current MM state already sent
    logic [W-1:0]  x_r, n_r, r2n_r;
    logic [EW-1:0] e_r;
    logic [LW-1:0] elen_r;
    logic [LW-1:0] idx;
    logic [W-1:0]  a_r, xt_r, result_r;
    logic [LW-1:0] elen_c;
    logic [EW-1:0] bit_mask;
    logic          accept, mm_state, mm_ack, e_bit, idx_zero;
    logic [W-1:0]  mm_res;
    logic          mm_unused;

    assign elen_c    = (e_len > EW_L) ? EW_L : e_len;
    assign accept    = (state == IDLE) && start && !start_q;
    assign mm_state  = (state == INIT_X) || (state == INIT_A) || (state == SQUARE) ||
                       (state == MULT)   || (state == POST);
    // mm_done in the start cycle is not a completion of this operation
    assign mm_ack    = mm_state && issued && mm_done;
    assign bit_mask  = {{(EW-1){1'b0}}, 1'b1} << idx;
    assign e_bit     = |(e_r & bit_mask);
    assign idx_zero  = (idx == '0);
    assign mm_res    = mm_result[W-1:0];
    assign mm_unused = mm_result[W];

    assign busy     = mm_state;
    assign done     = (state == DONE);
    assign mm_start = mm_state && !issued;
    assign result   = result_r;
    assign mm_m     = n_r;

    // Job operands, captured once per accepted job
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r    <= x;
            e_r    <= e;
            elen_r <= elen_c;
            n_r    <= n;
            r2n_r  <= r2n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            issued  <= 1'b0;
        end else begin
            state   <= state_d;
            start_q <= start;
            // cleared on completion so a re-entered state (SQUARE->SQUARE) pulses again
            issued  <= mm_state && !mm_ack;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (accept) state_d = INIT_X;
            INIT_X: if (mm_ack) state_d = INIT_A;
            INIT_A: if (mm_ack) state_d = (elen_r != '0) ? SQUARE : POST;
            SQUARE: if (mm_ack) state_d = e_bit ? MULT : (idx_zero ? POST : SQUARE);
            MULT:   if (mm_ack) state_d = idx_zero ? POST : SQUARE;
            POST:   if (mm_ack) state_d = DONE;
            // holding in DONE while start is high stops a held start from re-triggering
            DONE:   if (!start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mm_a = '0;
        mm_b = '0;
        case (state)
            INIT_X: begin mm_a = x_r;    mm_b = r2n_r; end
            INIT_A: begin mm_a = W'(1);  mm_b = r2n_r; end
            SQUARE: begin mm_a = a_r;    mm_b = a_r;   end
            MULT:   begin mm_a = a_r;    mm_b = xt_r;  end
            POST:   begin mm_a = a_r;    mm_b = W'(1); end
            default: ;
        endcase
    end

    // Destination registers and exponent bit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r      <= '0;
            xt_r     <= '0;
            result_r <= '0;
            idx      <= '0;
        end else if (mm_ack) begin
            case (state)
                INIT_X: xt_r <= mm_res;
                INIT_A: begin
                    a_r <= mm_res;
                    idx <= elen_r - LW'(1);
                end
                SQUARE: begin
                    a_r <= mm_res;
                    // a set bit keeps the index for the following MULT
                    if (!e_bit && !idx_zero) idx <= idx - LW'(1);
                end
                MULT: begin
                    a_r <= mm_res;
                    if (!idx_zero) idx <= idx - LW'(1);
                end
                POST: result_r <= mm_res;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mont_exp_ctrl.md
Name: mont_exp_ctrl

Overview:
Sequencer that computes result = x^e mod n with one shared Montgomery multiplier, using left-to-right square-and-multiply in the Montgomery domain. It sits between the rsa command/DMA front end and the montgomery instance. It owns the operand registers (X_tilde, accumulator A) and the operand muxing, and it issues one multiplication at a time. The host front end supplies x, e, n and r2n = R^2 mod n (R = 2^W), then pulses start.

Parameters:
W, 1024, operand/modulus width in bits; R = 2^W
EW, 1024, exponent register width in bits
LW, 11, width of e_len and of the bit-index counter (must satisfy 2^LW > EW)

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  asynchronous, active-high reset
start  in  1  level command; a job is accepted on the rising edge of start while IDLE
x  in  W  base, plain domain, x < n
e  in  EW  exponent
e_len  in  LW  number of significant exponent bits, processed from bit e_len-1 down to 0
n  in  W  modulus, odd
r2n  in  W  R^2 mod n
busy  out  1  high from job acceptance until DONE is entered
done  out  1  high while in DONE
result  out  W  registered x^e mod n; valid while done is high
mm_start  out  1  one-cycle start pulse to the multiplier
mm_a  out  W  multiplier operand a
mm_b  out  W  multiplier operand b
mm_m  out  W  multiplier modulus; equals n
mm_result  in  W+1  multiplier output; only bits [W-1:0] are used (multiplier guarantees result < n)
mm_done  in  1  multiplier completion, one-cycle pulse

Behaviour:
- Reset (async) values: state=IDLE, busy=0, done=0, mm_start=0, result=0, A=0, X_tilde=0, bit index=0. Reset mid-job aborts the job. No completion is reported, and the controller ignores any later mm_done.
- Inputs x, e, e_len, n, r2n are latched on acceptance. Later changes to them have no effect on the running job. If e_len > EW, it is clamped to EW.
- States: IDLE, INIT_X, INIT_A, SQUARE, MULT, POST, DONE.
- Multiplication operations per state (a, b; result destination):
  - INIT_X: (x, r2n) -> X_tilde
  - INIT_A: (1, r2n) -> A, giving R mod n
  - SQUARE: (A, A) -> A
  - MULT: (A, X_tilde) -> A
  - POST: (A, 1) -> result
- MM-state protocol:
  - mm_start is high exactly in the first cycle spent in each MM state.
  - mm_a and mm_b are stable for the whole state.
  - mm_done is ignored in the start cycle.
  - In the first later cycle with mm_done=1, the destination is written and the next state is taken on the following edge.
- Transitions:
  - IDLE -> INIT_X when the job is accepted.
  - INIT_X -> INIT_A.
  - INIT_A -> SQUARE with i = e_len-1 if e_len > 0; otherwise INIT_A -> POST.
  - SQUARE -> MULT if e[i] = 1. Otherwise SQUARE -> SQUARE with i-1, or SQUARE -> POST when i = 0.
  - MULT -> SQUARE with i-1, or MULT -> POST when i = 0.
  - POST -> DONE.
  - DONE -> IDLE once start = 0. While start stays high, the controller remains in DONE, which prevents a re-trigger deadlock.
- Operation count per job: 3 + e_len + popcount(e[e_len-1:0]). There are no idle cycles between operations beyond the one transition cycle.
- start asserted while busy is ignored. mm_done outside an MM state is ignored.
- e_len = 0 produces result = 1 mod n.
- The transition into DONE and the result write occur on the same edge.

Test Plan:
- W=8, n=13, r2n=3, x=5, e=3, e_len=2, behavioural MM model with a 5-cycle latency -> exactly 7 mm_start pulses; the sequence of (a,b) operand pairs is checked; done=1 with result=8.
- Same setup with x=2, e=10, e_len=4 -> 9 mm_start pulses; result=10; e bit order verified MSB-first from the MULT-state occurrences.
- e=0, e_len=0, x=7 -> 3 pulses (INIT_X, INIT_A, POST); result=1.
- Hold start high after done -> controller stays in DONE with no new mm_start; drop start -> IDLE next cycle; raise start again -> new job accepted.
- Assert reset while in SQUARE, then pulse mm_done -> busy=0, done=0, result=0; no state change follows; the next job runs correctly.
- Change x and e, and toggle start, mid-job -> no effect; result matches the values latched at acceptance.
